// File: rtl/gray_seq_ctrl.sv
// Gray-code sequencer: steps a 4-bit binary position on a prescaled cadence and
// presents its Gray code with a valid/ack handshake. Define GRAY_SEQ_WRAP_EN for modulo-16 stepping.
module gray_seq_ctrl #(
    parameter int unsigned STEP_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       dir,
    input  logic [3:0] limit,
    input  logic       gray_ack,
    output logic [3:0] bin_cnt,
    output logic [3:0] gray,
    output logic       valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_ACK,
        DONE
    } state_t;

    localparam logic [7:0] PRESC_LAST = 8'(STEP_DIV - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] presc;
    logic [7:0] presc_n;
    logic [3:0] bin_n;
    logic       valid_n;
    logic       dir_q;
    logic       dir_n;
    logic [3:0] limit_q;
    logic [3:0] limit_n;
    logic [3:0] step_val;
    logic       step_ovf;

    always_comb begin
        step_val = dir_q ? bin_cnt + 4'd1 : bin_cnt - 4'd1;
`ifdef GRAY_SEQ_WRAP_EN
        step_ovf = 1'b0;
`else
        // Saturating build: a step past either end finishes the sequence instead.
        step_ovf = dir_q ? (bin_cnt == 4'hF) : (bin_cnt == 4'h0);
`endif
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        bin_n   = bin_cnt;
        valid_n = valid;
        dir_n   = dir_q;
        limit_n = limit_q;
        busy    = (state != IDLE);
        done    = (state == DONE);
        if (stop) begin
            state_n = IDLE;
            presc_n = '0;
            valid_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_n   = dir;
                        limit_n = limit;
                        presc_n = '0;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (presc == PRESC_LAST) begin
                        presc_n = '0;
                        if (step_ovf) begin
                            state_n = DONE;
                        end else begin
                            bin_n   = step_val;
                            valid_n = 1'b1;
                            state_n = WAIT_ACK;
                        end
                    end else begin
                        presc_n = presc + 8'd1;
                    end
                end
                WAIT_ACK: begin
                    if (gray_ack) begin
                        valid_n = 1'b0;
                        if (bin_cnt == limit_q) begin
                            state_n = DONE;
                        end else begin
                            presc_n = '0;
                            state_n = RUN;
                        end
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // gray is derived from the next binary value so both registers change on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            presc   <= '0;
            bin_cnt <= '0;
            gray    <= '0;
            valid   <= 1'b0;
            dir_q   <= 1'b1;
            limit_q <= '0;
        end else begin
            state   <= state_n;
            presc   <= presc_n;
            bin_cnt <= bin_n;
            gray    <= bin_n ^ (bin_n >> 1);
            valid   <= valid_n;
            dir_q   <= dir_n;
            limit_q <= limit_n;
        end
    end

endmodule
